// File: rtl/vc_pop_sched.sv
// vc_pop_sched: pops one word per cycle from two VC FIFOs toward two destinations; VC_WRR_EN selects weighted round-robin, else VC0 strict priority.
// Latency: VC*_rd is combinational in the grant cycle; D*_push and vc_sel are registered one cycle later.
// Backpressure: a VC whose head destination is almost-full is ineligible and never stalls the other VC; init blocks all pops.
module vc_pop_sched #(
    parameter int WEIGHT = 4
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       init,
    input  logic       VC0_empty,
    input  logic       VC1_empty,
    input  logic       VC0_dest,
    input  logic       VC1_dest,
    input  logic       D0_full,
    input  logic       D1_full,
    output logic       VC0_rd,
    output logic       VC1_rd,
    output logic       D0_push,
    output logic       D1_push,
    output logic       vc_sel,
    output logic [1:0] state,
    output logic       idle
);

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    if (WEIGHT < 1 || WEIGHT > 15) begin : g_weight_range
        $error("vc_pop_sched: WEIGHT must be within 1..15");
    end

    state_t st;
    logic   vc0_elig;
    logic   vc1_elig;
    logic   pop_ok;
    logic   want0;
    logic   want1;
    logic   pop_any;
    logic   pop_dest;

`ifdef VC_WRR_EN
    localparam logic [3:0] WLIM = 4'(WEIGHT);
    logic [3:0] cnt;
`endif

    always_comb begin
        vc0_elig = !VC0_empty && !(VC0_dest ? D1_full : D0_full);
        vc1_elig = !VC1_empty && !(VC1_dest ? D1_full : D0_full);
        pop_ok   = (st == ST_IDLE || st == ST_ACTIVE) && !init;
`ifdef VC_WRR_EN
        // cnt counts VC0 grants made while VC1 was waiting; at WLIM VC1 gets its turn
        want0    = vc0_elig && (!vc1_elig || cnt < WLIM);
`else
        want0    = vc0_elig;
`endif
        want1    = vc1_elig && !want0;
    end

    assign VC0_rd   = pop_ok && want0;
    assign VC1_rd   = pop_ok && want1;
    assign pop_any  = VC0_rd || VC1_rd;
    assign pop_dest = VC0_rd ? VC0_dest : VC1_dest;
    assign state    = st;
    assign idle     = (st == ST_IDLE) && VC0_empty && VC1_empty;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            st      <= ST_RESET;
            D0_push <= 1'b0;
            D1_push <= 1'b0;
            vc_sel  <= 1'b0;
        end else begin
            D0_push <= pop_any && !pop_dest;
            D1_push <= pop_any && pop_dest;
            if (pop_any) begin
                vc_sel <= VC1_rd;
            end
            case (st)
                ST_RESET:  st <= ST_INIT;
                ST_INIT:   if (!init) st <= ST_IDLE;
                ST_IDLE: begin
                    if (init)                         st <= ST_INIT;
                    else if (!VC0_empty || !VC1_empty) st <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (init)                                      st <= ST_INIT;
                    else if (VC0_empty && VC1_empty && !pop_any)   st <= ST_IDLE;
                end
                default:   st <= ST_RESET;
            endcase
        end
    end

`ifdef VC_WRR_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt <= 4'd0;
        end else if (!vc1_elig || VC1_rd) begin
            cnt <= 4'd0;
        end else if (VC0_rd && cnt < WLIM) begin
            cnt <= cnt + 4'd1;
        end
    end
`endif

endmodule
